// File: rtl/xl_shared_vc_fifo.sv
// Shared-buffer multi-queue: VCN linked-list FIFOs in one DEPTH-entry store with
// per-VC reservation, shared-pool admission, occupancy cap and first-word-fall-through heads.
module xl_shared_vc_fifo #(
    parameter int VCN   = 8,
    parameter int D     = 32,
    parameter int DEPTH = 32,
    parameter int RSV   = 1,
    parameter int VCMAX = 32,
    localparam int A    = $clog2(DEPTH),
    localparam int TW   = (VCN > 1) ? $clog2(VCN) : 1
) (
    input  logic                 CLK,
    input  logic                 sRESET,
    input  logic                 wen,
    input  logic [TW-1:0]        tagw,
    input  logic [D-1:0]         din,
    input  logic                 ren,
    input  logic [TW-1:0]        tagr,
    output logic [VCN*D-1:0]     dout,
    output logic [VCN-1:0]       empty_n,
    output logic [VCN-1:0]       full_n,
    output logic [VCN*(A+1)-1:0] occ,
    output logic                 init_done,
    output logic                 err_ovf,
    output logic                 err_udf
);

    localparam int         SHARED   = DEPTH - VCN * RSV;
    localparam logic [A:0] RSV_C    = (A+1)'(RSV);
    localparam logic [A:0] VCMAX_C  = (A+1)'(VCMAX);
    localparam logic [A:0] SHARED_C = (A+1)'(SHARED);
    localparam logic [A:0] ONE_C    = (A+1)'(1);
    localparam logic [A-1:0] LAST_C = A'(DEPTH - 1);
    localparam logic [A-1:0] PONE_C = A'(1);

    typedef enum logic [1:0] {S_IDLE, S_WORK, S_DONE} init_state_e;

    init_state_e  state_q, state_d;
    logic [A-1:0] init_cnt_q;

    logic [A-1:0] fl_mem [DEPTH];
    logic [A-1:0] fl_rd_q, fl_wr_q;
    logic [D-1:0] mem_data [DEPTH];
    logic [A-1:0] mem_next [DEPTH];

    logic [A-1:0] head_q  [VCN];
    logic [A-1:0] head_d  [VCN];
    logic [A-1:0] tail_q  [VCN];
    logic [A-1:0] tail_d  [VCN];
    logic [D-1:0] hdata_q [VCN];
    logic [D-1:0] hdata_d [VCN];
    logic [A:0]   occ_q   [VCN];
    logic [A:0]   occ_d   [VCN];
    logic [A:0]   shared_used_q, shared_used_d;
    logic         err_ovf_q, err_udf_q;

    logic [VCN-1:0] ok;
    logic           wr_acc, rd_acc, same_vc, fl_push;
    logic [A-1:0]   alloc_ptr, rd_head, rd_next, fl_push_ptr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_WORK;
            S_WORK:  if (init_cnt_q == LAST_C) state_d = S_DONE;
            default: state_d = state_q;
        endcase
    end

    // Handshake: wen is a write valid qualified by ready full_n[tagw]; ren is a read valid
    // qualified by empty_n[tagr]. Both readies come from registered state only.
    for (genvar v = 0; v < VCN; v++) begin : g_vc
        assign ok[v] = init_done & (occ_q[v] < VCMAX_C)
                     & ((occ_q[v] < RSV_C) | (shared_used_q < SHARED_C));
        assign full_n[v]            = ok[v];
        assign empty_n[v]           = (occ_q[v] != '0);
        assign dout[v*D +: D]       = hdata_q[v];
        assign occ[v*(A+1) +: A+1]  = occ_q[v];
    end

    assign init_done = (state_q == S_DONE);
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;

    assign wr_acc    = wen & ok[tagw];
    assign rd_acc    = ren & empty_n[tagr];
    assign same_vc   = (tagw == tagr);
    assign alloc_ptr = fl_mem[fl_rd_q];
    assign rd_head   = head_q[tagr];
    assign rd_next   = mem_next[rd_head];

    assign fl_push     = (state_q == S_WORK) | rd_acc;
    assign fl_push_ptr = (state_q == S_WORK) ? init_cnt_q : rd_head;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        hdata_d       = hdata_q;
        occ_d         = occ_q;
        shared_used_d = shared_used_q;
        if (rd_acc) begin
            occ_d[tagr] = occ_q[tagr] - ONE_C;
            if (occ_q[tagr] != ONE_C) begin
                head_d[tagr]  = rd_next;
                hdata_d[tagr] = mem_data[rd_next];
            end
            if (occ_q[tagr] > RSV_C) shared_used_d = shared_used_d - ONE_C;
        end
        if (wr_acc) begin
            tail_d[tagw] = alloc_ptr;
            occ_d[tagw]  = occ_d[tagw] + ONE_C;
            if (occ_q[tagw] >= RSV_C) shared_used_d = shared_used_d + ONE_C;
            // The written word becomes head if the VC was empty or its only entry leaves now.
            if ((occ_q[tagw] == '0) || (rd_acc && same_vc && (occ_q[tagw] == ONE_C))) begin
                head_d[tagw]  = alloc_ptr;
                hdata_d[tagw] = din;
            end
        end
        if (wr_acc && rd_acc && same_vc) shared_used_d = shared_used_q;
    end

    always_ff @(posedge CLK) begin
        if (sRESET) begin
            state_q       <= S_IDLE;
            init_cnt_q    <= '0;
            fl_rd_q       <= '0;
            fl_wr_q       <= '0;
            shared_used_q <= '0;
            err_ovf_q     <= 1'b0;
            err_udf_q     <= 1'b0;
            for (int v = 0; v < VCN; v++) begin
                head_q[v]  <= '0;
                tail_q[v]  <= '0;
                hdata_q[v] <= '0;
                occ_q[v]   <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_WORK) init_cnt_q <= init_cnt_q + PONE_C;
            if (fl_push) fl_wr_q <= fl_wr_q + PONE_C;
            if (wr_acc) fl_rd_q <= fl_rd_q + PONE_C;
            shared_used_q <= shared_used_d;
            err_ovf_q     <= err_ovf_q | (wen & ~ok[tagw]);
            err_udf_q     <= err_udf_q | (ren & ~empty_n[tagr]);
            head_q  <= head_d;
            tail_q  <= tail_d;
            hdata_q <= hdata_d;
            occ_q   <= occ_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointer and occupancy state.
    always_ff @(posedge CLK) begin
        if (!sRESET) begin
            if (fl_push) fl_mem[fl_wr_q] <= fl_push_ptr;
            if (wr_acc) begin
                mem_data[alloc_ptr] <= din;
                if (occ_q[tagw] != '0) mem_next[tail_q[tagw]] <= alloc_ptr;
            end
        end
    end

endmodule

// File: tb/tb_xl_shared_vc_fifo.sv
// Bench for xl_shared_vc_fifo: directed scenarios plus a randomized run against a
// queue-based reference model of the shared-pool admission rules.
module tb_xl_shared_vc_fifo;

    localparam int VCN = 4, D = 8, DEPTH = 8, RSV = 1, VCMAX = 8, CAPMAX = 3;
    localparam int A = 3, TW = 2, SHARED = DEPTH - VCN * RSV;

    logic CLK = 1'b0;
    logic sRESET = 1'b1;
    logic wen = 1'b0, ren = 1'b0;
    logic [TW-1:0] tagw = '0, tagr = '0;
    logic [D-1:0]  din = '0;

    logic [VCN*D-1:0]     dout, dout_c;
    logic [VCN-1:0]       empty_n, full_n, empty_n_c, full_n_c;
    logic [VCN*(A+1)-1:0] occ, occ_c;
    logic init_done, err_ovf, err_udf, init_done_c, err_ovf_c, err_udf_c;

    int checks = 0;
    int failures = 0;

    logic [D-1:0] mq [VCN][$];
    bit m_ovf, m_udf, m_init;

    xl_shared_vc_fifo #(.VCN(VCN), .D(D), .DEPTH(DEPTH), .RSV(RSV), .VCMAX(VCMAX)) dut (
        .CLK(CLK), .sRESET(sRESET), .wen(wen), .tagw(tagw), .din(din), .ren(ren), .tagr(tagr),
        .dout(dout), .empty_n(empty_n), .full_n(full_n), .occ(occ), .init_done(init_done),
        .err_ovf(err_ovf), .err_udf(err_udf));

    xl_shared_vc_fifo #(.VCN(VCN), .D(D), .DEPTH(DEPTH), .RSV(RSV), .VCMAX(CAPMAX)) dut_c (
        .CLK(CLK), .sRESET(sRESET), .wen(wen), .tagw(tagw), .din(din), .ren(ren), .tagr(tagr),
        .dout(dout_c), .empty_n(empty_n_c), .full_n(full_n_c), .occ(occ_c),
        .init_done(init_done_c), .err_ovf(err_ovf_c), .err_udf(err_udf_c));

    always #5 CLK = ~CLK;

    function automatic logic [A:0] occ_of(input logic [VCN*(A+1)-1:0] vec, input int v);
        return vec[v*(A+1) +: A+1];
    endfunction

    function automatic logic [D-1:0] dout_of(input logic [VCN*D-1:0] vec, input int v);
        return vec[v*D +: D];
    endfunction

    function automatic int m_shared();
        int s = 0;
        for (int v = 0; v < VCN; v++)
            if (mq[v].size() > RSV) s += mq[v].size() - RSV;
        return s;
    endfunction

    function automatic bit m_ok(input int v);
        return m_init && (mq[v].size() < VCMAX) && ((mq[v].size() < RSV) || (m_shared() < SHARED));
    endfunction

    function automatic logic [VCN-1:0] m_full();
        logic [VCN-1:0] f;
        for (int v = 0; v < VCN; v++) f[v] = m_ok(v);
        return f;
    endfunction

    function automatic logic [VCN-1:0] m_empty();
        logic [VCN-1:0] e;
        for (int v = 0; v < VCN; v++) e[v] = (mq[v].size() > 0);
        return e;
    endfunction

    // One clock cycle of traffic; the model is advanced from the pre-edge state.
    task automatic cycle(input bit w, input int tw, input logic [D-1:0] d, input bit r, input int tr);
        bit ok_w, ne_r;
        wen = w; tagw = TW'(tw); din = d; ren = r; tagr = TW'(tr);
        ok_w = m_ok(tw);
        ne_r = (mq[tr].size() > 0);
        if (r) begin
            if (ne_r) void'(mq[tr].pop_front());
            else m_udf = 1'b1;
        end
        if (w) begin
            if (ok_w) mq[tw].push_back(d);
            else m_ovf = 1'b1;
        end
        @(posedge CLK); #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic reset_and_init(input bit chk);
        sRESET = 1'b1; wen = 1'b0; ren = 1'b0;
        for (int v = 0; v < VCN; v++) mq[v].delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_init = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        if (chk) begin
            checks++;
            if ({init_done, full_n, empty_n, occ, dout, err_ovf, err_udf} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got init=%b full_n=%h empty_n=%h occ=%h dout=%h ovf=%b udf=%b expected all zero",
                         init_done, full_n, empty_n, occ, dout, err_ovf, err_udf);
            end
        end
        sRESET = 1'b0;
        for (int c = 1; c <= DEPTH + 1; c++) begin
            @(posedge CLK); #1;
            if (chk && c <= DEPTH) begin
                checks++;
                if (init_done !== 1'b0 || full_n !== 4'h0 || init_done_c !== 1'b0) begin
                    failures++;
                    $display("FAIL init_wait c=%0d: got init=%b full_n=%h expected init=0 full_n=0",
                             c, init_done, full_n);
                end
            end
        end
        m_init = 1'b1;
        if (chk) begin
            checks++;
            if (init_done !== 1'b1 || full_n !== 4'hF || empty_n !== 4'h0 || occ !== '0 || init_done_c !== 1'b1) begin
                failures++;
                $display("FAIL init_done: got init=%b full_n=%h empty_n=%h occ=%h expected init=1 full_n=f empty_n=0 occ=0",
                         init_done, full_n, empty_n, occ);
            end
        end
    endtask

    task automatic test_reset();
        reset_and_init(1'b1);
    endtask

    task automatic test_ordering();
        logic [D-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        cycle(1, 0, vals[0], 0, 0);
        checks++;
        if (dout_of(dout, 0) !== 8'h11) begin
            failures++;
            $display("FAIL order_fwft: got %h expected 11", dout_of(dout, 0));
        end
        cycle(1, 0, vals[1], 0, 0);
        cycle(1, 0, vals[2], 0, 0);
        checks++;
        if (occ_of(occ, 0) !== 4'd3) begin
            failures++;
            $display("FAIL order_occ: got %0d expected 3", occ_of(occ, 0));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout_of(dout, 0) !== vals[i]) begin
                failures++;
                $display("FAIL order_read%0d: got %h expected %h", i, dout_of(dout, 0), vals[i]);
            end
            cycle(0, 0, '0, 1, 0);
        end
        checks++;
        if (empty_n[0] !== 1'b0 || occ_of(occ, 0) !== 4'd0) begin
            failures++;
            $display("FAIL order_empty: got empty_n=%b occ=%0d expected 0 0", empty_n[0], occ_of(occ, 0));
        end
    endtask

    task automatic test_shared_pool();
        reset_and_init(1'b0);
        for (int i = 0; i < 5; i++) cycle(1, 0, D'(8'h40 + i), 0, 0);
        checks++;
        if (full_n !== 4'b1110 || occ_of(occ, 0) !== 4'd5) begin
            failures++;
            $display("FAIL shared_vc0: got full_n=%b occ0=%0d expected 1110 5", full_n, occ_of(occ, 0));
        end
        cycle(1, 1, 8'h50, 0, 0);
        checks++;
        if (full_n !== 4'b1100) begin
            failures++;
            $display("FAIL shared_vc1: got full_n=%b expected 1100", full_n);
        end
        cycle(0, 0, '0, 1, 0);
        checks++;
        if (full_n !== 4'b1111 || dout_of(dout, 0) !== 8'h41) begin
            failures++;
            $display("FAIL shared_release: got full_n=%b head=%h expected 1111 41", full_n, dout_of(dout, 0));
        end
    endtask

    task automatic test_cap();
        reset_and_init(1'b0);
        for (int i = 0; i < 3; i++) cycle(1, 2, D'(8'h60 + i), 0, 0);
        checks++;
        if (full_n_c !== 4'b1011) begin
            failures++;
            $display("FAIL cap_full: got full_n=%b expected 1011", full_n_c);
        end
        cycle(1, 2, 8'h63, 0, 0);
        checks++;
        if (err_ovf_c !== 1'b1 || occ_of(occ_c, 2) !== 4'd3 || dout_of(dout_c, 2) !== 8'h60) begin
            failures++;
            $display("FAIL cap_drop: got ovf=%b occ2=%0d head=%h expected 1 3 60",
                     err_ovf_c, occ_of(occ_c, 2), dout_of(dout_c, 2));
        end
        checks++;
        if (err_ovf !== 1'b0 || occ_of(occ, 2) !== 4'd4) begin
            failures++;
            $display("FAIL cap_uncapped: got ovf=%b occ2=%0d expected 0 4", err_ovf, occ_of(occ, 2));
        end
    endtask

    task automatic test_same_vc();
        reset_and_init(1'b0);
        cycle(1, 3, 8'hAA, 0, 0);
        cycle(1, 3, 8'hBB, 1, 3);
        checks++;
        if (dout_of(dout, 3) !== 8'hBB || occ_of(occ, 3) !== 4'd1 || empty_n[3] !== 1'b1) begin
            failures++;
            $display("FAIL same_vc: got head=%h occ=%0d empty_n=%b expected bb 1 1",
                     dout_of(dout, 3), occ_of(occ, 3), empty_n[3]);
        end
        cycle(1, 3, 8'hCC, 0, 0);
        cycle(1, 3, 8'hDD, 1, 3);
        checks++;
        if (dout_of(dout, 3) !== 8'hCC || occ_of(occ, 3) !== 4'd2 || full_n !== m_full()) begin
            failures++;
            $display("FAIL same_vc_deep: got head=%h occ=%0d full_n=%b expected cc 2 %b",
                     dout_of(dout, 3), occ_of(occ, 3), full_n, m_full());
        end
    endtask

    task automatic test_underflow_and_reset();
        cycle(0, 0, '0, 1, 1);
        checks++;
        if (err_udf !== 1'b1 || err_ovf !== 1'b0 || empty_n !== m_empty() || occ_of(occ, 3) !== 4'd2) begin
            failures++;
            $display("FAIL underflow: got udf=%b ovf=%b empty_n=%b expected 1 0 %b",
                     err_udf, err_ovf, empty_n, m_empty());
        end
        sRESET = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({init_done, full_n, empty_n, occ, dout, err_ovf, err_udf} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got init=%b full_n=%h empty_n=%h occ=%h dout=%h udf=%b expected all zero",
                     init_done, full_n, empty_n, occ, dout, err_udf);
        end
        reset_and_init(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int wp = (i % 100 < 50) ? 75 : 30;
            bit w = ($urandom_range(0, 99) < wp);
            bit r = ($urandom_range(0, 99) < 100 - wp);
            int tw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, VCN - 1));
            cycle(w, tw, D'($urandom_range(0, 255)), r, int'($urandom_range(0, VCN - 1)));
            checks++;
            if (full_n !== m_full() || empty_n !== m_empty() || err_ovf !== m_ovf || err_udf !== m_udf) begin
                failures++;
                $display("FAIL rand_flags i=%0d: got full_n=%b empty_n=%b ovf=%b udf=%b expected %b %b %b %b",
                         i, full_n, empty_n, err_ovf, err_udf, m_full(), m_empty(), m_ovf, m_udf);
            end
            for (int v = 0; v < VCN; v++) begin
                checks++;
                if (occ_of(occ, v) !== (A+1)'(mq[v].size())) begin
                    failures++;
                    $display("FAIL rand_occ i=%0d vc=%0d: got %0d expected %0d", i, v, occ_of(occ, v), mq[v].size());
                end
                if (mq[v].size() > 0) begin
                    checks++;
                    if (dout_of(dout, v) !== mq[v][0]) begin
                        failures++;
                        $display("FAIL rand_head i=%0d vc=%0d: got %h expected %h", i, v, dout_of(dout, v), mq[v][0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_shared_pool();
        test_cap();
        test_same_vc();
        test_underflow_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
